// File: rtl/spi_adc_pkg.sv
// Shared state type, address width and sizing helper for the SPI ADC sequencer.
package spi_adc_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

   localparam int unsigned ADDR_BITS = 3;

   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned w;
      w = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/spi_adc_sequencer_if.sv
// Sample stream leaving the sequencer: head of the output FIFO plus valid/ready.
interface spi_adc_sequencer_if
   import spi_adc_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH = 16
);
   logic [SAMPLE_WIDTH-1:0] sample_data;
   logic [ADDR_BITS-1:0]    sample_channel;
   logic                    sample_valid;
   logic                    sample_ready;

   modport master (output sample_data, sample_channel, sample_valid, input sample_ready);
   modport slave  (input sample_data, sample_channel, sample_valid, output sample_ready);
endinterface

// File: rtl/spi_adc_sequencer_fifo.sv
// Synchronous FIFO holding {channel, sample} words; head entry shown combinationally.
module sample_fifo
   import spi_adc_pkg::*;
#(
   parameter int unsigned WIDTH = 19,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned AW = (DEPTH > 1) ? clogb2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign rdata_o = mem_q[rd_q];
   // A pop frees the slot, so a push into a full FIFO succeeds alongside it.
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= wdata_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (do_pop) rd_q <= rd_q + AW'(1);
         if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
         else if (do_pop && !do_push) cnt_q <= cnt_q - (AW+1)'(1);
      end
   end
endmodule

// File: rtl/spi_adc_sequencer.sv
// SPI master sequencing a multi-channel ADC round-robin into a sample FIFO.
// SAMPLE_SIGNED_EN: invert sample MSB at FIFO write (offset-binary to two's complement).
module spi_adc_sequencer
   import spi_adc_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH = 16,
   parameter int unsigned FRAME_BITS   = 16,
   parameter int unsigned CHANNELS     = 1,
   parameter int unsigned ADDR_OFFSET  = 2,
   parameter int unsigned CLOCK_DIVIDE = 4,
   parameter int unsigned FRAME_PERIOD = 1000,
   parameter int unsigned BUFFER_DEPTH = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   output logic                spi_clock,
   output logic                spi_chipselect,
   output logic                spi_address,
   input  logic                spi_data,
   output logic                overrun,
   spi_adc_sequencer_if.master stream
);
   localparam int unsigned DW = clogb2(CLOCK_DIVIDE);
   localparam int unsigned BW = (FRAME_BITS > 1) ? clogb2(FRAME_BITS) : 1;
   localparam int unsigned PW = clogb2(FRAME_PERIOD + 1);
   localparam int unsigned FW = ADDR_BITS + SAMPLE_WIDTH;

   state_e                  state_q;
   logic [DW-1:0]           div_q;
   logic [BW-1:0]           bit_q;
   logic [PW-1:0]           period_q;
   logic [ADDR_BITS-1:0]    chan_q, chan_d;
   logic [SAMPLE_WIDTH-1:0] rx_q, sample_w;
   logic                    sclk_q, cs_q, addr_q, overrun_q;
   logic                    div_last, push, pop, fifo_full, fifo_empty;
   logic [FW-1:0]           fifo_rdata;

   // Address for frame n is the channel whose sample arrives in frame n+1.
   function automatic logic addr_bit(input int unsigned idx, input logic [ADDR_BITS-1:0] ch);
      int unsigned          rel;
      logic [ADDR_BITS-1:0] sh;
      rel = idx - ADDR_OFFSET;
      sh  = ch << rel;
      return (rel < ADDR_BITS) ? sh[ADDR_BITS-1] : 1'b0;
   endfunction

   assign chan_d   = (chan_q == ADDR_BITS'(CHANNELS - 1)) ? '0 : chan_q + ADDR_BITS'(1);
   assign div_last = (div_q == DW'(CLOCK_DIVIDE - 1));
   assign push     = (state_q == HOLD) && div_last;
   assign pop      = stream.sample_valid && stream.sample_ready;

`ifdef SAMPLE_SIGNED_EN
   assign sample_w = rx_q ^ (SAMPLE_WIDTH'(1) << (SAMPLE_WIDTH - 1));
`else
   assign sample_w = rx_q;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         div_q     <= '0;
         bit_q     <= '0;
         period_q  <= '0;
         chan_q    <= '0;
         rx_q      <= '0;
         sclk_q    <= 1'b1;
         cs_q      <= 1'b1;
         addr_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= push && fifo_full && !pop;
         if (period_q != '0) period_q <= period_q - PW'(1);
         div_q <= div_last ? '0 : div_q + DW'(1);
         case (state_q)
            IDLE: begin
               div_q <= '0;
               if (enable && period_q == '0) begin
                  state_q  <= SETUP;
                  cs_q     <= 1'b0;
                  bit_q    <= '0;
                  period_q <= PW'(FRAME_PERIOD - 1);
               end
            end
            SETUP: if (div_last) begin
               state_q <= SHIFT;
               sclk_q  <= 1'b0;
               addr_q  <= addr_bit(0, chan_d);
            end
            SHIFT: if (div_last) begin
               if (!sclk_q) begin
                  sclk_q <= 1'b1;
                  rx_q   <= (rx_q << 1) | SAMPLE_WIDTH'(spi_data);
               end else if (bit_q == BW'(FRAME_BITS - 1)) begin
                  state_q <= HOLD;
                  addr_q  <= 1'b0;
               end else begin
                  sclk_q <= 1'b0;
                  bit_q  <= bit_q + BW'(1);
                  addr_q <= addr_bit(32'(bit_q) + 32'd1, chan_d);
               end
            end
            HOLD: if (div_last) begin
               state_q <= IDLE;
               cs_q    <= 1'b1;
               chan_q  <= chan_d;
            end
         endcase
      end
   end

   sample_fifo #(
      .WIDTH (FW),
      .DEPTH (BUFFER_DEPTH)
   ) u_fifo (
      .clk_i   (clock),
      .rst_i   (reset),
      .push_i  (push),
      .wdata_i ({chan_q, sample_w}),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign {stream.sample_channel, stream.sample_data} = fifo_rdata;
   assign stream.sample_valid = !fifo_empty;
   assign spi_clock           = sclk_q;
   assign spi_chipselect      = cs_q;
   assign spi_address         = addr_q;
   assign overrun             = overrun_q;
endmodule

// File: doc/spi_adc_sequencer.md
Name: spi_adc_sequencer

Overview:
- Parametrised successor to the single-channel 16-bit SPI sample front end used by the clap detector.
- Acts as SPI master to a multi-channel ADC (ADC128S022-class). Generates spi_clock and spi_chipselect and drives the channel address on spi_address.
- Captures one sample per frame at a programmable frame rate, sequencing round-robin over CHANNELS.
- Samples leave through a valid/ready stream via a small FIFO, feeding the detector datapath.

Parameters:
SAMPLE_WIDTH, 16, sample bits kept: the last SAMPLE_WIDTH bits of the frame; must be <= FRAME_BITS
FRAME_BITS, 16, spi_clock cycles per chip-select frame
CHANNELS, 1, channels sequenced, 1..8
ADDR_OFFSET, 2, bit index in the frame (0 = first bit) where the 3-bit address MSB starts
CLOCK_DIVIDE, 4, system clocks per spi_clock half-period, >= 2
FRAME_PERIOD, 1000, system clocks between frame starts
BUFFER_DEPTH, 4, output FIFO entries, power of 2

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
enable  in  1  permit new frames
spi_clock  out  1  SPI clock, idles high
spi_chipselect  out  1  active-low chip select
spi_address  out  1  MOSI, channel address
spi_data  in  1  MISO from ADC
sample_data  out  SAMPLE_WIDTH  captured sample
sample_channel  out  3  channel of sample_data
sample_valid  out  1  FIFO not empty
sample_ready  in  1  consumer accepts when high with sample_valid
overrun  out  1  one-cycle pulse: sample dropped, FIFO full

Behaviour:
- Reset values: spi_clock=1, spi_chipselect=1, spi_address=0, sample_valid=0, sample_data=0, sample_channel=0, overrun=0.
- Reset effects: FIFO flushed, channel sequence restarts at 0, period counter cleared.
- Reset mid-frame: spi_chipselect=1 and spi_clock=1 on the next clock; the partial sample is discarded.
- State machine: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
  - IDLE: cs=1. Go to SETUP when enable=1 and the period counter has expired.
  - SETUP: cs=0, spi_clock=1 for CLOCK_DIVIDE clocks.
  - SHIFT: FRAME_BITS bit cycles. Each bit cycle is CLOCK_DIVIDE clocks low, then CLOCK_DIVIDE clocks high.
  - HOLD: cs=0, spi_clock=1 for CLOCK_DIVIDE clocks, then cs=1, push to FIFO, return to IDLE.
- Period counter: restarts at each SETUP entry and expires FRAME_PERIOD clocks later, then saturates. If a frame is longer than FRAME_PERIOD, the next frame starts on the first IDLE clock.
- Edge timing:
  - spi_address changes on the clock where spi_clock falls (the ADC changes spi_data on the falling edge).
  - spi_data is registered on the clock where spi_clock rises.
  - Shift order is MSB-first.
- Address/sample alignment, frame n (n counted from reset):
  - spi_address carries (n+1) mod CHANNELS on bits ADDR_OFFSET..ADDR_OFFSET+2, MSB first; all other bits are 0.
  - The captured sample belongs to channel n mod CHANNELS, which is the address sent in frame n-1. Frame 0 is channel 0.
  - CHANNELS=1: spi_address stays 0.
- Capture: sample = the last SAMPLE_WIDTH received bits; leading bits are discarded.
- FIFO:
  - Push at the end of HOLD; pop when sample_valid && sample_ready.
  - Push and pop in the same cycle while full: both succeed.
  - Push while full with no pop: sample dropped, overrun pulses for 1 clock.
  - Push-to-sample_valid latency is 1 clock. Outputs show the head entry.
- enable deasserted mid-frame: the current frame completes and is pushed; no new frame starts. Sequence position is retained.

Optional Feature:
- SAMPLE_SIGNED_EN defined: the MSB of sample_data is inverted at FIFO write, converting offset-binary to two's complement.
- Undefined: sample_data is the raw received bits.

Decomposition:
- Shared package spi_adc_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, HOLD)
  - ADDR_BITS = 3
  - clogb2 function
- Sub-module sample_fifo (WIDTH, DEPTH): synchronous FIFO with full/empty. Stored word = {channel, sample}.

Test Plan:
- Defaults, enable=1, ADC model returns 16'hA5C3, sample_ready=1 -> cs low for 16 spi_clock cycles of 8 clocks each; sample_data=16'hA5C3, sample_channel=0; frame starts 1000 clocks apart.
- CHANNELS=4, FRAME_BITS=16, SAMPLE_WIDTH=12, model returns {4'h0, 12'h100+channel_addressed_prev} -> spi_address bits 2..4 = 1,2,3,0,1; samples 12'h100,12'h101,12'h102,12'h103 with channels 0,1,2,3.
- sample_ready=0 for 6 frames, BUFFER_DEPTH=4 -> sample_valid=1 after frame 1; overrun pulses after frames 5 and 6; draining yields the first 4 samples in order.
- reset=1 asserted mid-SHIFT (bit 7) -> next clock cs=1, spi_clock=1; FIFO empty; the next frame has sample_channel 0 and address 1.
- enable dropped during bit 3 of frame -> frame completes and sample is pushed; no further cs low for 3*FRAME_PERIOD clocks.
- SAMPLE_SIGNED_EN defined, model returns 16'h8000 then 16'h7FFF -> sample_data 16'h0000 then 16'hFFFF.
